// File: rtl/dff_ctrl_pkg.sv
// dff_ctrl_pkg
// Shared definitions for the D flip-flop lab sequencers: FSM state
// encoding, the LFSR tap mask, the default seed and the LFSR step function.
package dff_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Taps at bits 7,5,4,3 of the shift-left Fibonacci register
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Used in place of a zero seed, which would lock the LFSR at zero
  localparam logic [7:0] SEED_DEF = 8'h01;

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/dff_seq_ctrl_if.sv
// dff_seq_ctrl_if
// Bundles the run-control handshake, the result outputs and the DUT-facing
// D/Q/Qb lines of the flip-flop sequencer.
//   master : the sequencer (drives d and all results)
//   slave  : the host/bench side (drives start, num_vec, seed and q/qb)
interface dff_seq_ctrl_if #(
  parameter int VEC_W = 16
);
  logic             start;
  logic [VEC_W-1:0] num_vec;
  logic [7:0]       seed;
  logic             q;
  logic             qb;
  logic             d;
  logic             busy;
  logic             done;
  logic             pass;
  logic [VEC_W-1:0] err_cnt;
  logic [VEC_W-1:0] first_err;

  modport master (
    input  start, num_vec, seed, q, qb,
    output d, busy, done, pass, err_cnt, first_err
  );

  modport slave (
    output start, num_vec, seed, q, qb,
    input  d, busy, done, pass, err_cnt, first_err
  );

endinterface

// File: rtl/lfsr8.sv
// lfsr8
// 8-bit Fibonacci LFSR (shift left, feedback into bit 0).
//   clk, rst_n : clock, asynchronous active-low reset (loads RESET_VAL)
//   load       : load seed (has priority over en)
//   en         : advance one step
//   seed       : value loaded on load
//   state      : current register contents
module lfsr8 #(
  parameter logic [7:0] RESET_VAL = dff_ctrl_pkg::SEED_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] seed,
  output logic [7:0] state
);
  import dff_ctrl_pkg::*;

  // Load wins over advance so a new run always starts from its own seed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET_VAL;
    end else if (load) begin
      state <= seed;
    end else if (en) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/dff_seq_ctrl.sv
// dff_seq_ctrl
// Self-checking sequencer for the gate-level D flip-flop lab block. On start
// it drives a pseudo-random stream onto the DUT's D input, compares each
// captured bit against Q/Qb one cycle after capture and reports the error
// count, first failing index and a pass flag.
//   clk, rst_n       : clock, asynchronous active-low reset
//   bus.start        : run request, sampled in IDLE only
//   bus.num_vec      : number of comparisons, captured at start
//   bus.seed         : LFSR seed, captured at start (0 -> SEED_DEF)
//   bus.q / bus.qb   : DUT outputs
//   bus.d            : DUT data input (registered)
//   bus.busy         : high from start acceptance until DONE exits
//   bus.done         : one-cycle pulse at end of run
//   bus.pass         : last run had zero errors
//   bus.err_cnt      : saturating mismatch count
//   bus.first_err    : index of first mismatch, all-ones if none
module dff_seq_ctrl #(
  parameter int         VEC_W    = 16,
  parameter logic [7:0] SEED_DEF = dff_ctrl_pkg::SEED_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  dff_seq_ctrl_if.master      bus
);
  import dff_ctrl_pkg::*;

  localparam logic [VEC_W-1:0] ONE = {{(VEC_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [VEC_W-1:0] nvec;
  logic [VEC_W-1:0] idx;
  logic             exp_bit;
  logic             exp_vld;
  logic             d_r;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;
  logic [VEC_W-1:0] err_cnt_r;
  logic [VEC_W-1:0] first_err_r;

  logic [7:0]       lfsr_q;
  logic [7:0]       seed_eff;
  logic             lfsr_load;
  logic             lfsr_en;
  logic             mismatch;
  logic             unused_lfsr;

  assign seed_eff  = (bus.seed == 8'h00) ? SEED_DEF : bus.seed;
  assign lfsr_load = (state == S_IDLE) && bus.start;
  assign lfsr_en   = (state == S_PRIME) || (state == S_RUN);

  // A healthy flip-flop shows the expected bit on Q and its complement on Qb
  assign mismatch  = (bus.q != exp_bit) || (bus.qb != ~bus.q);

  // Only bit 0 is driven out; the upper bits matter only inside the generator
  assign unused_lfsr = ^lfsr_q[7:1];

  lfsr8 #(
    .RESET_VAL(SEED_DEF)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .en    (lfsr_en),
    .seed  (seed_eff),
    .state (lfsr_q)
  );

  // exp_bit is the D value the DUT captured on the previous edge, so each
  // comparison samples Q a full cycle after capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      nvec        <= '0;
      idx         <= '0;
      exp_bit     <= 1'b0;
      exp_vld     <= 1'b0;
      d_r         <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      err_cnt_r   <= '0;
      first_err_r <= '1;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            nvec        <= bus.num_vec;
            idx         <= '0;
            exp_vld     <= 1'b0;
            err_cnt_r   <= '0;
            first_err_r <= '1;
            pass_r      <= 1'b0;
            busy_r      <= 1'b1;
            state       <= (bus.num_vec == '0) ? S_DONE : S_PRIME;
          end
        end
        S_PRIME: begin
          d_r   <= lfsr_q[0];
          state <= S_RUN;
        end
        S_RUN: begin
          d_r     <= lfsr_q[0];
          exp_bit <= d_r;
          exp_vld <= 1'b1;
          if (exp_vld) begin
            if (mismatch) begin
              if (err_cnt_r != '1) begin
                err_cnt_r <= err_cnt_r + ONE;
              end
              if (first_err_r == '1) begin
                first_err_r <= idx;
              end
            end
            idx <= idx + ONE;
            if (idx == nvec - ONE) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done_r <= 1'b1;
          pass_r <= (err_cnt_r == '0);
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.d         = d_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.pass      = pass_r;
  assign bus.err_cnt   = err_cnt_r;
  assign bus.first_err = first_err_r;

endmodule

// File: tb/tb_dff_seq_ctrl.sv
// tb_dff_seq_ctrl
// Bench for dff_seq_ctrl. An ideal DFF model (or a faulty variant) feeds
// Q/Qb back; expected results come from the stream rule and the comparison
// schedule of the sequencer, evaluated with plain arithmetic.
module tb_dff_seq_ctrl;

  localparam int VEC_W = 16;
  localparam int MAXT  = 65600;

  logic clk = 1'b0;
  logic rst_n;
  logic ffq = 1'b0;

  int checks = 0;
  int errors = 0;

  bit qlog    [MAXT];
  bit qblog   [MAXT];
  bit dseen   [MAXT];
  bit expbits [MAXT];

  dff_seq_ctrl_if #(.VEC_W(VEC_W)) bus ();

  dff_seq_ctrl #(.VEC_W(VEC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Ideal flip-flop under test: captures D on every rising edge
  always @(posedge clk) ffq <= bus.d;

  // Bit stream a seed produces: bit k is l[0] before the k-th advance
  task automatic gen_bits(input logic [7:0] s, input int n);
    int l;
    int fb;
    l = (s == 8'h00) ? 1 : int'(s);
    for (int k = 0; k < n + 2; k++) begin
      expbits[k] = bit'(l & 1);
      fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
      l  = ((l << 1) | fb) & 255;
    end
  endtask

  // mode 0 ideal, 1 Q stuck at 0, 2 Qb equal to Q, 3 random faults
  task automatic drive_q(input int mode);
    case (mode)
      0: begin bus.q = ffq;  bus.qb = ~ffq; end
      1: begin bus.q = 1'b0; bus.qb = 1'b1; end
      2: begin bus.q = ffq;  bus.qb = ffq;  end
      default: begin
        bus.q  = ffq ^ ($urandom_range(0, 3) == 0);
        bus.qb = ($urandom_range(0, 3) == 0) ? bus.q : ~bus.q;
      end
    endcase
  endtask

  task automatic run_scenario(input string name, input logic [7:0] s, input int n,
                              input int mode, input bit pulse_start, input bit hold_start);
    int done_t;
    int exp_done;
    int cnt;
    int first_k;
    int dbad;
    logic d_before;
    logic [15:0] exp_err;
    logic [15:0] exp_first;
    gen_bits(s, n);
    @(negedge clk);
    d_before    = bus.d;
    bus.start   = 1'b1;
    bus.num_vec = 16'(n);
    bus.seed    = s;
    drive_q(mode);
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s busy_on_accept: got %b expected 1", name, bus.busy);
    end
    done_t = -1;
    for (int t = 1; t <= n + 10; t++) begin
      @(negedge clk);
      if (!hold_start) begin
        if (pulse_start && t >= 2 && t <= n + 2) begin
          bus.start   = 1'($urandom);
          bus.num_vec = 16'($urandom);
          bus.seed    = 8'($urandom);
        end else begin
          bus.start = 1'b0;
        end
      end
      drive_q(mode);
      qlog[t]  = bus.q;
      qblog[t] = bus.qb;
      @(posedge clk); #1;
      dseen[t] = bus.d;
      if (bus.done === 1'b1) begin
        done_t = t;
        break;
      end
    end
    exp_done = (n == 0) ? 1 : n + 3;
    checks++;
    if (done_t != exp_done) begin
      errors++;
      $display("[TB] FAIL %s done_cycle: got %0d expected %0d", name, done_t, exp_done);
    end
    // Comparison k happens 3+k edges after acceptance against bit k
    cnt = 0;
    first_k = -1;
    dbad = 0;
    for (int k = 0; k < n; k++) begin
      if ((qlog[3 + k] != expbits[k]) || (qblog[3 + k] == qlog[3 + k])) begin
        cnt++;
        if (first_k < 0) first_k = k;
      end
      if (dseen[1 + k] != expbits[k]) dbad++;
    end
    if (n == 0 && dseen[1] != d_before) dbad++;
    exp_err   = (cnt > 65535) ? 16'hFFFF : 16'(cnt);
    exp_first = (first_k < 0) ? 16'hFFFF : 16'(first_k);
    checks++;
    if (dbad != 0) begin
      errors++;
      $display("[TB] FAIL %s d_sequence: got %0d wrong bits expected 0", name, dbad);
    end
    checks++;
    if (bus.err_cnt !== exp_err) begin
      errors++;
      $display("[TB] FAIL %s err_cnt: got %h expected %h", name, bus.err_cnt, exp_err);
    end
    checks++;
    if (bus.first_err !== exp_first) begin
      errors++;
      $display("[TB] FAIL %s first_err: got %h expected %h", name, bus.first_err, exp_first);
    end
    checks++;
    if (bus.pass !== (cnt == 0)) begin
      errors++;
      $display("[TB] FAIL %s pass: got %b expected %b", name, bus.pass, (cnt == 0));
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s busy_after_done: got %b expected 0", name, bus.busy);
    end
    @(negedge clk);
    if (!hold_start) bus.start = 1'b0;
    drive_q(mode);
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s done_width: got %b expected 0", name, bus.done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.num_vec = '0;
    bus.seed = 8'h00;
    bus.q = 1'b0;
    bus.qb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.d, bus.busy, bus.done, bus.pass} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 0000", {bus.d, bus.busy, bus.done, bus.pass});
    end
    checks++;
    if (bus.err_cnt !== 16'h0000 || bus.first_err !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL reset_counts: got %h/%h expected 0000/ffff", bus.err_cnt, bus.first_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [4:0] got;
    run_scenario("basic", 8'h01, 8, 0, 1'b0, 1'b0);
    got = {dseen[1], dseen[2], dseen[3], dseen[4], dseen[5]};
    checks++;
    if (got !== 5'b10001) begin
      errors++;
      $display("[TB] FAIL basic_first_bits: got %b expected 10001", got);
    end
  endtask

  task automatic test_stuck_q();
    run_scenario("stuck_q", 8'h01, 5, 1, 1'b0, 1'b0);
    checks++;
    if (bus.err_cnt !== 16'd2 || bus.first_err !== 16'd0) begin
      errors++;
      $display("[TB] FAIL stuck_q_literal: got %0d/%0d expected 2/0", bus.err_cnt, bus.first_err);
    end
  endtask

  task automatic test_reset_mid_run();
    int bad;
    gen_bits(8'h5A, 10);
    @(negedge clk);
    bus.start = 1'b1;
    bus.num_vec = 16'd10;
    bus.seed = 8'h5A;
    drive_q(0);
    @(posedge clk);
    bad = 0;
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      bus.start = 1'b0;
      drive_q(0);
      @(posedge clk); #1;
      if (bus.d != expbits[t - 1]) bad++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL midrst_d_before: got %0d wrong bits expected 0", bad);
    end
    checks++;
    if ({bus.d, bus.busy, bus.done, bus.pass} !== 4'b0000 ||
        bus.err_cnt !== 16'h0000 || bus.first_err !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL midrst_outputs: got %b %h %h expected 0000 0000 ffff",
               {bus.d, bus.busy, bus.done, bus.pass}, bus.err_cnt, bus.first_err);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_scenario("midrst_rerun", 8'h5A, 10, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int seen;
    run_scenario("b2b_first", 8'h33, 3, 0, 1'b0, 1'b1);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_relaunch: got busy %b expected 1", bus.busy);
    end
    seen = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      bus.start = 1'b0;
      drive_q(0);
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (seen != 1 || bus.err_cnt !== 16'h0000 || bus.pass !== 1'b1 || bus.first_err !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL b2b_second: got done %0d err %h pass %b first %h expected 1 0000 1 ffff",
               seen, bus.err_cnt, bus.pass, bus.first_err);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      run_scenario("random", 8'($urandom), $urandom_range(1, 40), 3, 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stuck_q();
    run_scenario("qb_eq_q", 8'h01, 4, 2, 1'b0, 1'b0);
    run_scenario("zero_vec", 8'h77, 0, 0, 1'b0, 1'b0);
    test_reset_mid_run();
    run_scenario("start_ignored", 8'hC3, 20, 3, 1'b1, 1'b0);
    run_scenario("seed_zero", 8'h00, 8, 0, 1'b0, 1'b0);
    test_back_to_back();
    test_random();
    run_scenario("saturate", 8'h9E, 65535, 2, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
